// File: rtl/pwm_motor_ctrl.sv
// Multi-channel PWM driver for an L298 H-bridge: switch bytes become speed/direction
// targets, duty ramps on period boundaries, and reversals pass through zero duty plus dead time.
module pwm_motor_ctrl #(
    parameter int CHANNELS     = 2,
    parameter int CNT_W        = 8,
    parameter int PRESCALE     = 390,
    parameter int RAMP_STEP    = 16,
    parameter int DEAD_PERIODS = 4
) (
    input  logic                  w5,
    input  logic                  rst_n,
    input  logic [8*CHANNELS-1:0] sw,
    input  logic                  en,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic [CHANNELS-1:0]   in_a,
    output logic [CHANNELS-1:0]   in_b,
    output logic [CHANNELS-1:0]   fault,
    output logic                  period_tick
);

    localparam int PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DUTY_W = CNT_W + 1;
    localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
    localparam logic [DUTY_W-1:0] FULL = {1'b1, {CNT_W{1'b0}}};
    localparam logic [DUTY_W:0]   STEP = RAMP_STEP[DUTY_W:0];

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;

    logic [8*CHANNELS-1:0] sw_s1, sw_s2;
    logic                  en_s1, en_s2;
    logic [PSC_W-1:0]      psc;
    logic [CNT_W-1:0]      cnt;
    logic                  step;
    logic                  pb;

    always_ff @(posedge w5 or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            en_s1 <= 1'b0;
            en_s2 <= 1'b0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            en_s1 <= en;
            en_s2 <= en_s1;
        end
    end

    assign step        = (psc == PSC_W'(PRESCALE - 1));
    assign pb          = step && (cnt == '1);
    assign period_tick = pb;

    always_ff @(posedge w5 or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            cnt <= '0;
        end else if (step) begin
            psc <= '0;
            cnt <= cnt + 1'b1;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    // Highest set bit of the nibble selects the speed level.
    function automatic logic [DUTY_W-1:0] decode(input logic [3:0] nib);
        if (nib[3])      decode = FULL;
        else if (nib[2]) decode = FULL - (FULL >> 2);
        else if (nib[1]) decode = FULL >> 1;
        else if (nib[0]) decode = FULL >> 2;
        else             decode = '0;
    endfunction

    // One ramp step toward tgt, clamped so it never overshoots or wraps.
    function automatic logic [DUTY_W-1:0] ramp(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] gap;
        up  = {1'b0, cur} + STEP;
        gap = {1'b0, cur} - {1'b0, tgt};
        if (cur < tgt)      ramp = (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        else if (gap > STEP) ramp = cur - STEP[DUTY_W-1:0];
        else                ramp = tgt;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [3:0]        fwd_nib, rev_nib;
            logic              fwd_on, rev_on, conflict;
            logic [DUTY_W-1:0] level_t, ramp_tgt;
            state_t            dir_t;
            state_t            state;
            logic [DUTY_W-1:0] duty_cur;
            logic [DEAD_W-1:0] dead_cnt;
            logic              pwm_reg, in_a_reg, in_b_reg, fault_reg;

            assign fwd_nib  = sw_s2[8*gi +: 4];
            assign rev_nib  = sw_s2[8*gi+4 +: 4];
            assign fwd_on   = |fwd_nib;
            assign rev_on   = |rev_nib;
            assign conflict = fwd_on && rev_on;

            // ramp_tgt is nonzero only when the request matches the running direction,
            // which also keeps it at 0 in IDLE and DEAD.
            always_comb begin
                level_t  = '0;
                dir_t    = (rev_on && !fwd_on) ? REV : FWD;
                if (en_s2 && !conflict) level_t = fwd_on ? decode(fwd_nib) : decode(rev_nib);
                ramp_tgt = ((level_t != '0) && (dir_t == state)) ? level_t : '0;
            end

            always_ff @(posedge w5 or negedge rst_n) begin
                if (!rst_n) begin
                    state     <= IDLE;
                    duty_cur  <= '0;
                    dead_cnt  <= '0;
                    pwm_reg   <= 1'b0;
                    in_a_reg  <= 1'b0;
                    in_b_reg  <= 1'b0;
                    fault_reg <= 1'b0;
                end else begin
                    fault_reg <= conflict;
                    pwm_reg   <= ({1'b0, cnt} < duty_cur) && ((state == FWD) || (state == REV));
                    if (pb) begin
                        case (state)
                            IDLE: begin
                                if (level_t != '0) begin
                                    state    <= dir_t;
                                    duty_cur <= '0;
                                    in_a_reg <= (dir_t == FWD);
                                    in_b_reg <= (dir_t == REV);
                                end
                            end
                            FWD, REV: begin
                                if ((duty_cur == '0) && (ramp_tgt == '0)) begin
                                    in_a_reg <= 1'b0;
                                    in_b_reg <= 1'b0;
                                    if ((level_t != '0) && (dir_t != state)) begin
                                        state    <= DEAD;
                                        dead_cnt <= DEAD_W'(DEAD_PERIODS - 1);
                                    end else begin
                                        state <= IDLE;
                                    end
                                end else begin
                                    duty_cur <= ramp(duty_cur, ramp_tgt);
                                end
                            end
                            DEAD: begin
                                if (dead_cnt == '0) state <= IDLE;
                                else                dead_cnt <= dead_cnt - 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end

            assign pwm_out[gi] = pwm_reg;
            assign in_a[gi]    = in_a_reg;
            assign in_b[gi]    = in_b_reg;
            assign fault[gi]   = fault_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Scoreboard bench for pwm_motor_ctrl: a period-level reference model predicts every
// cycle's outputs into a queue, and a negedge monitor pops and compares them.
module tb_pwm_motor_ctrl;

    localparam int CH     = 2;
    localparam int PERIOD = 16;
    localparam int STEP   = 4;
    localparam int DEADP  = 2;
    localparam int M_IDLE = 0, M_FWD = 1, M_REV = 2, M_DEAD = 3;

    logic        w5 = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] sw = 16'h0;
    logic [1:0]  pwm_out, in_a, in_b, fault;
    logic        period_tick;

    int tests = 0;
    int fails = 0;

    // packing: {tick, fault[1:0], in_b[1:0], in_a[1:0], pwm[1:0]}
    logic [8:0] exp_q[$];

    int          m_mode[CH];
    int          m_duty[CH];
    int          m_dead[CH];
    int          k;
    logic [15:0] sw_p1, sw_p2;
    logic        en_p1, en_p2;

    pwm_motor_ctrl #(
        .CHANNELS(CH), .CNT_W(4), .PRESCALE(1), .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP)
    ) dut (
        .w5(w5), .rst_n(rst_n), .sw(sw), .en(en),
        .pwm_out(pwm_out), .in_a(in_a), .in_b(in_b), .fault(fault),
        .period_tick(period_tick)
    );

    always #5 w5 = ~w5;

    function automatic int nib_level(input logic [3:0] n);
        if (n[3]) return 16;
        if (n[2]) return 12;
        if (n[1]) return 8;
        if (n[0]) return 4;
        return 0;
    endfunction

    function automatic int toward(input int cur, input int tgt);
        if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
        if (cur > tgt) return (cur - STEP < tgt) ? tgt : cur - STEP;
        return cur;
    endfunction

    task automatic model_reset();
        k = 0;
        sw_p1 = '0; sw_p2 = '0;
        en_p1 = 1'b0; en_p2 = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = M_IDLE; m_duty[c] = 0; m_dead[c] = 0;
        end
    endtask

    // Inputs seen at edge k act on logic at edge k+2; edge k ends period when k%16==15.
    task automatic model_edge();
        logic [8:0] e;
        logic [3:0] fn, rn;
        int lvl, want, tgt;
        bit pb, fon, ron;
        e  = '0;
        pb = (k % PERIOD) == PERIOD - 1;
        for (int c = 0; c < CH; c++) begin
            fn  = sw_p2[8*c +: 4];
            rn  = sw_p2[8*c+4 +: 4];
            fon = (fn != 0);
            ron = (rn != 0);
            e[6+c] = fon && ron;
            lvl = 0;
            if (en_p2 && !(fon && ron)) lvl = fon ? nib_level(fn) : nib_level(rn);
            want = (ron && !fon) ? M_REV : M_FWD;
            e[c] = ((k % PERIOD) < m_duty[c]) && (m_mode[c] == M_FWD || m_mode[c] == M_REV);
            if (pb) begin
                case (m_mode[c])
                    M_IDLE: if (lvl > 0) m_mode[c] = want;
                    M_FWD, M_REV: begin
                        tgt = (lvl > 0 && want == m_mode[c]) ? lvl : 0;
                        if (m_duty[c] == 0 && tgt == 0) begin
                            if (lvl > 0) begin
                                m_mode[c] = M_DEAD;
                                m_dead[c] = DEADP - 1;
                            end else begin
                                m_mode[c] = M_IDLE;
                            end
                        end else begin
                            m_duty[c] = toward(m_duty[c], tgt);
                        end
                    end
                    default: begin
                        if (m_dead[c] == 0) m_mode[c] = M_IDLE;
                        else                m_dead[c]--;
                    end
                endcase
            end
            e[2+c] = (m_mode[c] == M_FWD);
            e[4+c] = (m_mode[c] == M_REV);
        end
        e[8] = ((k + 1) % PERIOD) == PERIOD - 1;
        exp_q.push_back(e);
        k++;
        sw_p2 = sw_p1; sw_p1 = sw;
        en_p2 = en_p1; en_p1 = en;
    endtask

    always @(posedge w5) begin
        if (!rst_n) model_reset();
        else        model_edge();
    end

    always @(negedge w5) begin
        logic [8:0] act, e;
        act = {period_tick, fault, in_b, in_a, pwm_out};
        if (!rst_n) begin
            exp_q.delete();
            tests++;
            if (act !== 9'd0) begin
                fails++;
                $display("FAIL reset_state t=%0t: got %b, expected all zero", $time, act);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL outputs t=%0t: got tick=%b fault=%b in_b=%b in_a=%b pwm=%b, expected tick=%b fault=%b in_b=%b in_a=%b pwm=%b",
                         $time, act[8], act[7:6], act[5:4], act[3:2], act[1:0],
                         e[8], e[7:6], e[5:4], e[3:2], e[1:0]);
            end
            tests++;
            if ((in_a & in_b) !== 2'b00) begin
                fails++;
                $display("FAIL bridge_overlap t=%0t: in_a=%b in_b=%b, required no common bit", $time, in_a, in_b);
            end
        end
    end

    // Called and returning at posedge+2.
    task automatic run_seg(input logic [15:0] s, input logic e, input int cycles);
        sw = s;
        en = e;
        $display("[TB] segment sw=%h en=%b cycles=%0d", s, e, cycles);
        repeat (cycles) @(posedge w5);
        #2;
    endtask

    task automatic reset_pulse();
        logic [6:0] act;
        #1 rst_n = 1'b0;
        #1;
        act = {pwm_out, in_a, in_b, period_tick};
        tests++;
        if (act !== 7'd0) begin
            fails++;
            $display("FAIL async_reset t=%0t: got %b, expected all zero", $time, act);
        end
        $display("[TB] reset pulse at t=%0t", $time);
        repeat (2) @(posedge w5);
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return {4'h0, 4'($urandom_range(1, 15))};
            2:       return {4'($urandom_range(1, 15)), 4'h0};
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge w5);
        #2 rst_n = 1'b1;

        run_seg(16'h0008, 1'b1, 56);
        reset_pulse();
        run_seg(16'h0008, 1'b1, 100);
        run_seg(16'h0080, 1'b1, 240);
        run_seg(16'h0011, 1'b1, 120);
        run_seg(16'h0001, 1'b1, 120);
        run_seg(16'h0404, 1'b1, 150);
        run_seg(16'h0404, 1'b0, 120);
        run_seg(16'h0006, 1'b1, 120);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) reset_pulse();
            run_seg({rand_byte(), rand_byte()}, ($urandom_range(0, 7) != 0),
                    int'($urandom_range(8, 200)));
        end

        repeat (3) @(posedge w5);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_motor_ctrl.md
Name: pwm_motor_ctrl

Overview:
Multi-channel PWM motor driver for the L298 H-bridge on the PMOD JC header, successor to the single-channel switch-to-duty controller. Each channel decodes a switch byte into a speed level and direction, then ramps its duty cycle toward that target on PWM period boundaries. A direction reversal always passes through zero duty and a dead-time interval before the bridge inputs flip. Sits between the board switches/pins and the bridge ENx/INx pins.

Parameters:
CHANNELS, 2, number of independent motor channels
CNT_W, 8, PWM counter width; period = 2**CNT_W counter steps
PRESCALE, 390, w5 cycles per counter step (100 MHz gives about 1 kHz PWM); must be >= 1
RAMP_STEP, 16, duty change per PWM period; must be >= 1
DEAD_PERIODS, 4, whole PWM periods spent in coast before a direction change; must be >= 1

Ports:
w5  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
sw  in  8*CHANNELS  switch byte per channel, channel i at [8i+7:8i]; [3:0] forward, [7:4] reverse
en  in  1  global enable; low forces every target to 0
pwm_out  out  CHANNELS  bridge ENA/ENB, PWM drive
in_a  out  CHANNELS  bridge IN1/IN3
in_b  out  CHANNELS  bridge IN2/IN4
fault  out  CHANNELS  high while forward and reverse switches are set at the same time
period_tick  out  1  one-cycle pulse on the last w5 cycle of each PWM period

Behaviour:
- Reset, asynchronous: every register is 0. All outputs are 0 and every channel is in IDLE.
- sw and en each pass through a 2-flop synchroniser before any use, giving 2 cycles of input latency.
- Prescaler: counts 0..PRESCALE-1 and wraps. step is high on count PRESCALE-1.
- PWM counter cnt (CNT_W bits): increments on step and wraps 2**CNT_W-1 to 0.
- Period boundary pb = step AND cnt == all-ones. period_tick is pb.
- Duty registers are CNT_W+1 bits wide. FULL = 2**CNT_W.
- pwm_out[i] is registered: (cnt < duty_cur[i]) AND state is FWD or REV. Output latency is 1 cycle. duty FULL gives a constant 1; duty 0 gives a constant 0.
- Decode of each nibble, highest bit wins:
  - bit3 gives FULL.
  - bit2 gives 3*FULL/4.
  - bit1 gives FULL/2.
  - bit0 gives FULL/4.
  - No bit set gives 0.
- Target selection:
  - Forward nibble nonzero and reverse nibble zero: dir_t = FWD, level from the forward nibble.
  - Reverse nonzero only: dir_t = REV, level from the reverse nibble.
  - Both nonzero: level_t = 0 and fault[i] = 1, registered. fault clears 1 cycle after the conflict clears.
  - en low: level_t = 0 with no abrupt cut; the channel ramps down.
- Ramp: on pb only, duty_cur moves toward ramp_tgt by RAMP_STEP and clamps at the target, never overshooting. Unsigned arithmetic with no wrap: saturate at 0 and at FULL.
- Per-channel FSM. All transitions are evaluated on pb only.
  - IDLE: in_a = in_b = 0 and ramp_tgt = 0. If level_t > 0, go to FWD or REV per dir_t with duty_cur = 0, then ramp up.
  - FWD: in_a = 1, in_b = 0.
    - If level_t > 0 and dir_t = FWD: ramp_tgt = level_t (it may rise or fall).
    - Otherwise: ramp_tgt = 0.
    - When duty_cur == 0 and ramp_tgt == 0: go to DEAD if level_t > 0 and dir_t = REV, else go to IDLE.
  - REV: mirror of FWD with in_a = 0, in_b = 1.
  - DEAD: in_a = in_b = 0, pwm_out = 0. Load dead_cnt = DEAD_PERIODS-1 on entry and decrement each pb. At 0, go to IDLE. IDLE then starts the new direction on the next pb.
- Guarantees:
  - in_a and in_b are never both 1.
  - in_a/in_b change only while duty_cur == 0.
  - The reversal sequence is FWD(ramp to 0) → DEAD → IDLE → REV.
- Switch changes mid-ramp retarget at the next pb.
- rst_n asserted mid-operation drops all outputs to 0 immediately.
- Channels are fully independent except for the shared prescaler and counter.

Test Plan:
All scenarios use sim params PRESCALE=1, CNT_W=4 (FULL=16), RAMP_STEP=4, DEAD_PERIODS=2.
- Reset, then sw=0x08 on ch0 with en=1 → ch0 enters FWD; duty_cur steps 4, 8, 12, 16 at successive pb. pwm_out high 4/16, then 8/16, 12/16 counts, then constant 1. in_a=1, in_b=0.
- From ch0 FWD at 16, set sw=0x80 → duty steps down 12, 8, 4, 0. Then DEAD for 2 periods with in_a=in_b=0 and pwm_out=0. Then IDLE for 1 period, then REV (in_b=1) ramping to 16. in_a and in_b are never both 1.
- sw=0x11 → fault[0]=1 within 3 cycles, target 0, ramp down to IDLE. Clear to 0x01 → fault drops and ch0 ramps to duty 4 forward.
- en=0 while ch1 runs at 12 → ch1 ramps 8, 4, 0, then IDLE. ch0 behaves the same, independently.
- Pulse rst_n low mid-period with ch0 at duty 8 → pwm_out, in_a, in_b and period_tick are 0 in the same cycle. Release → restart from IDLE with duty 0.
- sw=0x06 → highest-bit priority gives 12/16 duty. period_tick pulses exactly every 16 cycles.
